// File: rtl/tx_frame_sequencer.sv
// Frames one crypto result into one or two header-tagged messages for the UART tx path.
// MIXED mode sends the raw block first and then the encrypted block, with no bubble between them.
module tx_frame_sequencer #(
  parameter int unsigned MESSAGE_SIZE = 512,
  parameter int unsigned HEADER_SIZE  = 32,
  parameter logic [7:0]  MAGIC        = 8'hA5
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    src_valid_in,
  output logic                    src_ready_out,
  input  logic [MESSAGE_SIZE-1:0] enc_in,
  input  logic [MESSAGE_SIZE-1:0] dec_in,
  input  logic [1:0]              mode_in,
  output logic [MESSAGE_SIZE-1:0] msg_out,
  output logic [HEADER_SIZE-1:0]  header_out,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic                    err_out,
  output logic [7:0]              seq_out
);

  // state  | meaning
  // IDLE   | waiting for a source result
  // SEND_A | first (or only) frame presented
  // SEND_B | encrypted half of a MIXED result presented
  typedef enum logic [1:0] {IDLE = 2'd0, SEND_A = 2'd1, SEND_B = 2'd2} state_t;

  localparam logic [1:0] MODE_MIXED   = 2'b00;
  localparam logic [1:0] MODE_RAW     = 2'b01;
  localparam logic [1:0] MODE_ENC     = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;
  localparam logic [1:0] TYPE_RAW     = 2'b01;
  localparam logic [1:0] TYPE_ENC     = 2'b10;
  localparam logic [7:0] BYTE_LEN     = 8'(MESSAGE_SIZE / 8);

  state_t                  state, state_nxt;
  logic [MESSAGE_SIZE-1:0] msg, enc_pend;
  logic [HEADER_SIZE-1:0]  header;
  logic                    mixed, err;
  logic [7:0]              seq;
  logic                    accept, handshake;

  function automatic logic [HEADER_SIZE-1:0] make_header(input logic [1:0] typ, input logic [7:0] s);
    return {MAGIC, typ, 6'b0, s, BYTE_LEN};
  endfunction

  assign valid_out     = (state != IDLE);
  assign src_ready_out = (state == IDLE) && rst_in;
  assign accept        = (state == IDLE) && src_valid_in;
  assign handshake     = valid_out && ready_in;
  assign msg_out       = msg;
  assign header_out    = header;
  assign err_out       = err;
  assign seq_out       = seq;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && (mode_in != MODE_ILLEGAL)) state_nxt = SEND_A;
      SEND_A:  if (ready_in) state_nxt = mixed ? SEND_B : IDLE;
      SEND_B:  if (ready_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state    <= IDLE;
      msg      <= '0;
      enc_pend <= '0;
      header   <= '0;
      mixed    <= 1'b0;
      err      <= 1'b0;
      seq      <= 8'd0;
    end else begin
      state <= state_nxt;
      err   <= accept && (mode_in == MODE_ILLEGAL);
      if (handshake) seq <= seq + 8'd1;
      if (accept) begin
        case (mode_in)
          MODE_RAW: begin
            msg    <= dec_in;
            header <= make_header(TYPE_RAW, seq);
            mixed  <= 1'b0;
          end
          MODE_ENC: begin
            msg    <= enc_in;
            header <= make_header(TYPE_ENC, seq);
            mixed  <= 1'b0;
          end
          MODE_MIXED: begin
            msg      <= dec_in;
            header   <= make_header(TYPE_RAW, seq);
            enc_pend <= enc_in;
            mixed    <= 1'b1;
          end
          default: ;
        endcase
      end else if (handshake && (state == SEND_A) && mixed) begin
        // the counter advances on this same edge, so the second half carries seq+1
        msg    <= enc_pend;
        header <= make_header(TYPE_ENC, seq + 8'd1);
      end
    end
  end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Bench for tx_frame_sequencer: a frame-queue model checked every cycle, plus directed
// scenarios with literal expectations and a randomized run.
module tb_tx_frame_sequencer;
  localparam int MS = 512;

  logic          clk = 1'b0;
  logic          rst_n, src_valid, src_ready, valid, ready, err;
  logic [MS-1:0] enc, dec, msg;
  logic [31:0]   header;
  logic [1:0]    mode;
  logic [7:0]    seq;

  always #5 clk = ~clk;

  tx_frame_sequencer dut (
    .clk_in(clk), .rst_in(rst_n), .src_valid_in(src_valid), .src_ready_out(src_ready),
    .enc_in(enc), .dec_in(dec), .mode_in(mode), .msg_out(msg), .header_out(header),
    .valid_out(valid), .ready_in(ready), .err_out(err), .seq_out(seq)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [MS-1:0] msg;
    logic [1:0]    typ;
  } frame_t;

  frame_t     q[$];
  logic [7:0] m_seq = 8'd0;
  bit         m_err = 1'b0;

  task automatic check(input string name, input logic [MS-1:0] act, input logic [MS-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkn(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [MS-1:0] rnd();
    logic [MS-1:0] r;
    for (int i = 0; i < MS / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Model: pending frames live in a queue; the front frame is on the bus and its
  // header sequence number is simply the count of frames already delivered.
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_seq = 8'd0;
      m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (q.size() != 0) begin
        if (ready) begin
          void'(q.pop_front());
          m_seq = m_seq + 8'd1;
        end
      end else if (src_valid) begin
        case (mode)
          2'b01: q.push_back('{dec, 2'b01});
          2'b10: q.push_back('{enc, 2'b10});
          2'b00: begin
            q.push_back('{dec, 2'b01});
            q.push_back('{enc, 2'b10});
          end
          default: m_err = 1'b1;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkn("valid_out", 32'(valid), 32'(q.size() != 0));
      checkn("src_ready_out", 32'(src_ready), 32'((q.size() == 0) && rst_n));
      checkn("err_out", 32'(err), 32'(m_err));
      checkn("seq_out", 32'(seq), 32'(m_seq));
      if (q.size() != 0) begin
        check("msg_out", msg, q[0].msg);
        checkn("header_out", header, {8'hA5, q[0].typ, 6'b0, m_seq, 8'd64});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    src_valid = 1'b0;
    repeat (n) cyc();
    rst_n = 1'b1;
  endtask

  logic [MS-1:0] d_val, e_val;

  initial begin
    rst_n = 1'b0; src_valid = 1'b0; ready = 1'b0; mode = 2'b00; enc = '0; dec = '0;
    cyc();
    chk_en = 1'b1;
    cyc();
    @(negedge clk);
    checkn("rst valid", 32'(valid), 32'd0);
    checkn("rst src_ready", 32'(src_ready), 32'd0);
    checkn("rst seq", 32'(seq), 32'd0);
    checkn("rst header", header, 32'd0);
    check("rst msg", msg, '0);
    checkn("rst err", 32'(err), 32'd0);
    cyc();

    // RAW single
    rst_n = 1'b1; src_valid = 1'b1; mode = 2'b01; dec = 512'h1234; ready = 1'b1;
    cyc();
    src_valid = 1'b0;
    @(negedge clk);
    checkn("raw valid", 32'(valid), 32'd1);
    check("raw msg", msg, 512'h1234);
    checkn("raw header", header, 32'hA5400040);
    cyc();
    @(negedge clk);
    checkn("raw idle valid", 32'(valid), 32'd0);
    checkn("raw idle ready", 32'(src_ready), 32'd1);
    checkn("raw seq", 32'(seq), 32'd1);

    // MIXED with backpressure; inputs change after capture
    cyc();
    do_reset(2);
    d_val = rnd(); e_val = rnd();
    src_valid = 1'b1; mode = 2'b00; dec = d_val; enc = e_val; ready = 1'b0;
    cyc();
    src_valid = 1'b0; dec = rnd(); enc = rnd();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mixed hold msg", msg, d_val);
      checkn("mixed hold header", header, 32'hA5400040);
      cyc();
    end
    ready = 1'b1;
    cyc();
    @(negedge clk);
    checkn("mixed B valid", 32'(valid), 32'd1);
    check("mixed B msg", msg, e_val);
    checkn("mixed B header", header, 32'hA5800140);
    cyc();
    @(negedge clk);
    checkn("mixed seq", 32'(seq), 32'd2);
    checkn("mixed done valid", 32'(valid), 32'd0);

    // ENC back-to-back with src_valid held high
    cyc();
    do_reset(2);
    src_valid = 1'b1; mode = 2'b10; ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e_val = rnd();
      enc = e_val;
      cyc();
      @(negedge clk);
      checkn("enc header", header, {8'hA5, 2'b10, 6'b0, 8'(k), 8'd64});
      check("enc msg", msg, e_val);
      checkn("enc src_ready low", 32'(src_ready), 32'd0);
      cyc();
      if (k == 2) src_valid = 1'b0;
    end
    @(negedge clk);
    checkn("enc seq", 32'(seq), 32'd3);

    // Illegal mode
    cyc();
    mode = 2'b11; src_valid = 1'b1;
    cyc();
    src_valid = 1'b0;
    @(negedge clk);
    checkn("illegal err", 32'(err), 32'd1);
    checkn("illegal valid", 32'(valid), 32'd0);
    checkn("illegal ready", 32'(src_ready), 32'd1);
    cyc();
    @(negedge clk);
    checkn("illegal err off", 32'(err), 32'd0);
    checkn("illegal seq", 32'(seq), 32'd3);

    // Sequence wrap: 255 RAW frames, then MIXED
    cyc();
    do_reset(1);
    src_valid = 1'b1; mode = 2'b01; ready = 1'b1;
    repeat (509) cyc();
    src_valid = 1'b0;
    cyc();
    @(negedge clk);
    checkn("wrap preload seq", 32'(seq), 32'hFF);
    cyc();
    src_valid = 1'b1; mode = 2'b00;
    cyc();
    src_valid = 1'b0;
    @(negedge clk);
    checkn("wrap first seq field", 32'(header[15:8]), 32'hFF);
    cyc();
    @(negedge clk);
    checkn("wrap second seq field", 32'(header[15:8]), 32'h00);
    checkn("wrap second type", 32'(header[23:22]), 32'd2);
    cyc();
    @(negedge clk);
    checkn("wrap final seq", 32'(seq), 32'h01);

    // Reset while in SEND_B
    cyc();
    src_valid = 1'b1; mode = 2'b00; ready = 1'b1;
    cyc();
    src_valid = 1'b0;
    cyc();
    ready = 1'b0;
    cyc();
    rst_n = 1'b0;
    cyc();
    @(negedge clk);
    checkn("midrst valid", 32'(valid), 32'd0);
    checkn("midrst seq", 32'(seq), 32'd0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    checkn("midrst release ready", 32'(src_ready), 32'd1);

    // Randomized traffic with occasional resets
    repeat (3000) begin
      cyc();
      rst_n     = ($urandom_range(0, 63) != 0);
      src_valid = $urandom_range(0, 1);
      mode      = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      ready     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) != 0) begin
        enc = rnd();
        dec = rnd();
      end
    end
    cyc();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
